// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, opcode encoding and legality helper.
package alu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_AND  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  localparam logic [ALU_OP_W-1:0] ALU_OP_LAST = 4'b1010;

  function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
    return op <= ALU_OP_LAST;
  endfunction

endpackage

// File: rtl/alu.sv
// Fixed 32-bit combinational ALU; undefined opcodes produce zero.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_OP_W-1:0] op,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  output logic [XLEN-1:0]     result
);

  always_comb begin
    result = '0;
    case (alu_op_e'(op))
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  result = a ^ b;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      // Upper-immediate is pre-shifted by the requester; pass operand b.
      ALU_LUI:  result = b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  always_comb begin
    int unsigned        j;
    logic [IDX_W-1:0]   idx;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    j         = 0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = 32'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = IDX_W'(j);
      if (!gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_idx   = idx;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// One ALU shared by NUM_REQ requesters: RR grant -> operand reg -> ALU -> per-requester rsp buffer.
// Define ALU_ARB_ILLEGAL_OP_EN to flag opcodes above ALU_LUI with o_rsp_err and zero data.
module alu_share_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = alu_pkg::XLEN
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  output logic [NUM_REQ-1:0]      o_req_ready,
  input  logic [4*NUM_REQ-1:0]    i_req_op,
  input  logic [XLEN*NUM_REQ-1:0] i_req_a,
  input  logic [XLEN*NUM_REQ-1:0] i_req_b,
  output logic [NUM_REQ-1:0]      o_rsp_valid,
  input  logic [NUM_REQ-1:0]      i_rsp_ready,
  output logic [XLEN*NUM_REQ-1:0] o_rsp_data,
  output logic [NUM_REQ-1:0]      o_rsp_err
);
  import alu_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic                   s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0]       s1_id_q, s1_id_d;
  logic [ALU_OP_W-1:0]    s1_op_q, s1_op_d;
  logic [XLEN-1:0]        s1_a_q, s1_a_d;
  logic [XLEN-1:0]        s1_b_q, s1_b_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;

  logic [NUM_REQ-1:0]             rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0][XLEN-1:0]   rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0]   busy, eligible, gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_valid;
  logic [ALU_OP_W-1:0]  sel_op;
  logic [XLEN-1:0]      sel_a, sel_b;
  logic [XLEN-1:0]      alu_result, s1_result;

  // A requester whose response slot drains this cycle may be granted again.
  always_comb begin
    busy = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      busy[k] = (s1_valid_q && (s1_id_q == IDX_W'(k))) || (rsp_valid_q[k] && !i_rsp_ready[k]);
    end
    eligible = i_req_valid & ~busy & {NUM_REQ{!i_reset}};
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (eligible),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign o_req_ready = gnt;

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        sel_op = i_req_op[4*k +: 4];
        sel_a  = i_req_a[XLEN*k +: XLEN];
        sel_b  = i_req_b[XLEN*k +: XLEN];
      end
    end
  end

  always_comb begin
    s1_valid_d = gnt_valid;
    s1_id_d    = s1_id_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    ptr_d      = ptr_q;
    if (gnt_valid) begin
      s1_id_d = gnt_idx;
      s1_op_d = sel_op;
      s1_a_d  = sel_a;
      s1_b_d  = sel_b;
      ptr_d   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      ptr_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      ptr_q      <= ptr_d;
    end
  end

  alu u_alu (
    .op     (s1_op_q),
    .a      (s1_a_q),
    .b      (s1_b_q),
    .result (alu_result)
  );

`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic                 s1_illegal;
  logic [NUM_REQ-1:0]   rsp_err_q, rsp_err_d;

  assign s1_illegal = !is_legal_op(s1_op_q);
  assign s1_result  = s1_illegal ? '0 : alu_result;

  always_comb begin
    rsp_err_d = rsp_err_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (s1_valid_q && (s1_id_q == IDX_W'(k))) rsp_err_d[k] = s1_illegal;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) rsp_err_q <= '0;
    else         rsp_err_q <= rsp_err_d;
  end

  assign o_rsp_err = rsp_err_q;
`else
  assign s1_result = alu_result;
  assign o_rsp_err = '0;
`endif

  // Refill wins over drain so a same-edge consume+complete keeps the slot valid.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (s1_valid_q && (s1_id_q == IDX_W'(k))) begin
        rsp_valid_d[k] = 1'b1;
        rsp_data_d[k]  = s1_result;
      end else if (rsp_valid_q[k] && i_rsp_ready[k]) begin
        rsp_valid_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with two requesters.
module tb_alu_share_arbiter;

  localparam int unsigned N = 2;
  localparam int unsigned W = 32;

`ifdef ALU_ARB_ILLEGAL_OP_EN
  localparam logic [31:0] EXP_ILL_ERR = 32'd1;
`else
  localparam logic [31:0] EXP_ILL_ERR = 32'd0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [4*N-1:0]   req_op;
  logic [W*N-1:0]   req_a, req_b, rsp_data;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(
    .NUM_REQ (N),
    .XLEN    (W)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_op    (req_op),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_err   (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    req_op[4*k +: 4] = op;
    req_a[W*k +: W]  = a;
    req_b[W*k +: W]  = b;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '1;

    // Reset: no grants even with requests pending, outputs cleared.
    tick();
    req_valid = 2'b11;
    #1 check("ready_in_reset", 32'(req_ready), 32'h0);
    tick();
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data0", rsp_data[31:0], 32'h0);
    check("rst_rsp_data1", rsp_data[63:32], 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    req_valid = '0;
    rst       = 1'b0;

    // Single ADD on requester 0.
    drive(0, 4'd0, 32'd5, 32'd3);
    req_valid = 2'b01;
    #1 check("add_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    check("add_rsp_pending", 32'(rsp_valid), 32'h0);
    tick();
    check("add_rsp_valid", 32'(rsp_valid), 32'h1);
    check("add_data", rsp_data[31:0], 32'd8);
    tick();
    check("add_rsp_drained", 32'(rsp_valid), 32'h0);

    // Return pointer to 0, then simultaneous SUB / SLTU.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 4'd1, 32'd0, 32'd1);
    drive(1, 4'd3, 32'd1, 32'hFFFF_FFFF);
    req_valid = 2'b11;
    #1 check("dual_ready_first", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b10;
    #1 check("dual_ready_second", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    check("sub_rsp_valid", 32'(rsp_valid), 32'h1);
    check("sub_data", rsp_data[31:0], 32'hFFFF_FFFF);
    tick();
    check("sltu_rsp_valid", 32'(rsp_valid), 32'h2);
    check("sltu_data", rsp_data[63:32], 32'h1);
    tick();
    check("dual_drained", 32'(rsp_valid), 32'h0);

    // Continuous contention: grants alternate, starting at requester 0.
    drive(0, 4'd0, 32'd10, 32'd1);
    drive(1, 4'd0, 32'd20, 32'd2);
    req_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      #1 check($sformatf("alt_grant_%0d", i), 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
    end
    req_valid = '0;
    tick();
    tick();
    check("alt_drained", 32'(rsp_valid), 32'h0);
    check("alt_data0", rsp_data[31:0], 32'd11);
    check("alt_data1", rsp_data[63:32], 32'd22);

    // SRA with a stalled consumer: held result, no regrant until consumed.
    drive(1, 4'd9, 32'h8000_0000, 32'd4);
    rsp_ready = 2'b01;
    req_valid = 2'b10;
    #1 check("sra_ready", 32'(req_ready), 32'h2);
    tick();
    #1 check("sra_busy_s1", 32'(req_ready), 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("sra_hold_valid_%0d", i), 32'(rsp_valid), 32'h2);
      check($sformatf("sra_hold_data_%0d", i), rsp_data[63:32], 32'hF800_0000);
      check($sformatf("sra_no_grant_%0d", i), 32'(req_ready), 32'h0);
      tick();
    end
    rsp_ready = 2'b11;
    #1 check("sra_consume_regrant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    check("sra_slot_cleared", 32'(rsp_valid), 32'h0);
    tick();
    check("sra_refilled", 32'(rsp_valid), 32'h2);
    check("sra_refill_data", rsp_data[63:32], 32'hF800_0000);
    tick();

    // Reset one cycle after a transfer discards the in-flight op.
    drive(0, 4'd0, 32'd7, 32'd7);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b10;
    rst       = 1'b1;
    #1 check("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    req_valid = '0;
    rst       = 1'b0;
    check("mid_rst_rsp0", 32'(rsp_valid), 32'h0);
    tick();
    check("mid_rst_rsp1", 32'(rsp_valid), 32'h0);
    tick();
    check("mid_rst_rsp2", 32'(rsp_valid), 32'h0);

    // Pointer back at 0; opcode above LUI and a LUI.
    drive(0, 4'b1100, 32'd1, 32'd2);
    drive(1, 4'd10, 32'd0, 32'h1234_5000);
    req_valid = 2'b11;
    #1 check("post_rst_ptr", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b10;
    tick();
    req_valid = '0;
    check("ill_rsp_valid", 32'(rsp_valid), 32'h1);
    check("ill_data", rsp_data[31:0], 32'h0);
    check("ill_err", 32'(rsp_err[0]), EXP_ILL_ERR);
    tick();
    check("lui_rsp_valid", 32'(rsp_valid), 32'h2);
    check("lui_data", rsp_data[63:32], 32'h1234_5000);
    check("lui_err", 32'(rsp_err[1]), 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
